// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned P_CPU         = 0;
  localparam int unsigned P_DBG         = 1;
  localparam int unsigned MEM_WORDS_DEF = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: masked requests, ptr breaks ties, one-hot grant.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] req;

  always_comb begin
    req   = valid & mask;
    grant = '0;
    if (req == 2'b11) begin
      grant[ptr] = 1'b1;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU (port 0) and loader/debug (port 1).
// Optional ownership locking is compiled in with DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned MAX_LOCK  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic        req0_lock,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic        req1_lock,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  logic [1:0]  valid, mask, grant;
  logic        ptr, granted, sel;
  logic        err0, err1, sel_we, sel_err;
  logic [31:0] sel_addr, sel_wd;
  arb_state_e  state;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= MEM_WORDS);
  endfunction

  assign err0  = addr_bad(req0_addr);
  assign err1  = addr_bad(req1_addr);
  // Gating valids with reset keeps ready and mem_we low in reset cycles.
  assign valid = reset ? 2'b00 : {req1_valid, req0_valid};

  always_comb begin
    mask = 2'b11;
    case (state)
      OWN0:    mask = 2'b01;
      OWN1:    mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  rr_arb2 u_rr (
    .valid (valid),
    .ptr   (ptr),
    .mask  (mask),
    .grant (grant)
  );

  assign req0_ready = grant[P_CPU];
  assign req1_ready = grant[P_DBG];
  assign granted    = |grant;
  assign sel        = grant[P_DBG];

  assign sel_we   = sel ? req1_we    : req0_we;
  assign sel_err  = sel ? err1       : err0;
  assign sel_addr = sel ? req1_addr  : req0_addr;
  assign sel_wd   = sel ? req1_wdata : req0_wdata;

  assign mem_we = granted & sel_we & ~sel_err;
  assign mem_a  = granted ? sel_addr : '0;
  assign mem_wd = granted ? sel_wd   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= grant[P_CPU];
      rsp0_err   <= grant[P_CPU] & err0;
      rsp0_rdata <= (grant[P_CPU] && !req0_we && !err0) ? mem_rd : '0;
      rsp1_valid <= grant[P_DBG];
      rsp1_err   <= grant[P_DBG] & err1;
      rsp1_rdata <= (grant[P_DBG] && !req1_we && !err1) ? mem_rd : '0;
    end
  end

  // After any grant the other port gets priority; the lock-expiry hand-off is the same rule.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (granted) begin
      ptr <= grant[P_CPU];
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned LW = $clog2(MAX_LOCK + 1);

  arb_state_e  state_nx;
  logic [LW-1:0] lcnt, lcnt_nx;
  logic        sel_lock;

  assign sel_lock = sel ? req1_lock : req0_lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      lcnt  <= '0;
    end else begin
      state <= state_nx;
      lcnt  <= lcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lcnt_nx  = lcnt;
    if (granted) begin
      case (state)
        ARB: begin
          if (sel_lock && MAX_LOCK > 1) begin
            state_nx = sel ? OWN1 : OWN0;
            lcnt_nx  = LW'(1);
          end
        end
        default: begin
          if (!sel_lock || (32'(lcnt) + 32'd1 >= MAX_LOCK)) begin
            state_nx = ARB;
            lcnt_nx  = '0;
          end else begin
            lcnt_nx = lcnt + LW'(1);
          end
        end
      endcase
    end
  end
`else
  logic unused_lock;

  assign state       = ARB;
  assign unused_lock = ^{req0_lock, req1_lock, MAX_LOCK[0]};
`endif

endmodule
